// File: rtl/mem_access_stage_if.sv
// Bundle of EX/MEM inputs, dmemory bus and MEM/WB outputs around the memory stage.
// master is the stage itself; slave is the pipeline/dmemory side that talks to it.
interface mem_access_stage_if;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_reg_en;

    logic        mem_stall;

    logic [31:0] dmem_address;
    logic        dmem_read_write;
    logic [31:0] dmem_data_in;
    logic [1:0]  dmem_access_size;
    logic [31:0] dmem_data_out;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_en;
    logic [31:0] wb_data;
    logic        wb_fault;

    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_data, ex_result, ex_rd, ex_reg_en, dmem_data_out,
        output mem_stall, dmem_address, dmem_read_write, dmem_data_in,
               dmem_access_size, wb_valid, wb_rd, wb_reg_en, wb_data, wb_fault
    );

    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr,
               ex_store_data, ex_result, ex_rd, ex_reg_en, dmem_data_out,
        input  mem_stall, dmem_address, dmem_read_write, dmem_data_in,
               dmem_access_size, wb_valid, wb_rd, wb_reg_en, wb_data, wb_fault
    );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory stage: drives dmemory, extends load data, performs SB/SH as a
// two-cycle read-modify-write, range-checks every access and registers MEM/WB.
module mem_access_stage #(
    parameter logic [31:0] DMEM_BASE  = 32'h0100_0000,
    parameter int unsigned DMEM_BYTES = 1048576
) (
    input  logic                clock,
    input  logic                reset,
    mem_access_stage_if.master  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    localparam logic [32:0] LO_LIMIT = {1'b0, DMEM_BASE};
    localparam logic [32:0] HI_LIMIT = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  size_q, size_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_en_q, wb_reg_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_fault_q, wb_fault_d;

    logic [32:0] size_bytes;
    logic [32:0] addr_ext;
    logic        in_range;
    logic        is_mem;
    logic        illegal_f3;
    logic        fault;
    logic [31:0] load_data;

    // Access decode: size, range check, funct3 legality and load extraction.
    always_comb begin
        unique case (bus.ex_funct3[1:0])
            2'b00:   size_bytes = 33'd1;
            2'b01:   size_bytes = 33'd2;
            default: size_bytes = 33'd4;
        endcase

        addr_ext = {1'b0, bus.ex_addr};
        // Carry bit keeps accesses near 2^32 from wrapping back into range.
        in_range = (addr_ext >= LO_LIMIT) && ((addr_ext + size_bytes) <= HI_LIMIT);

        is_mem     = bus.ex_is_load | bus.ex_is_store;
        illegal_f3 = (bus.ex_is_load  && !(bus.ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
                   | (bus.ex_is_store && !(bus.ex_funct3 inside {3'b000, 3'b001, 3'b010}));
        fault      = bus.ex_valid & is_mem
                   & (!in_range | illegal_f3 | (bus.ex_is_load & bus.ex_is_store));

        unique case (bus.ex_funct3)
            3'b000:  load_data = {{24{bus.dmem_data_out[7]}},  bus.dmem_data_out[7:0]};
            3'b100:  load_data = {24'b0,                       bus.dmem_data_out[7:0]};
            3'b001:  load_data = {{16{bus.dmem_data_out[15]}}, bus.dmem_data_out[15:0]};
            3'b101:  load_data = {16'b0,                       bus.dmem_data_out[15:0]};
            default: load_data = bus.dmem_data_out;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        size_d      = size_q;

        wb_valid_d  = 1'b0;
        wb_rd_d     = 5'd0;
        wb_reg_en_d = 1'b0;
        wb_data_d   = 32'd0;
        wb_fault_d  = 1'b0;

        bus.mem_stall        = 1'b0;
        bus.dmem_address     = bus.ex_addr;
        bus.dmem_read_write  = 1'b0;
        bus.dmem_data_in     = bus.ex_store_data;
        bus.dmem_access_size = bus.ex_funct3[1:0];

        unique case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = bus.ex_rd;
                    if (!is_mem) begin
                        wb_reg_en_d = bus.ex_reg_en;
                        wb_data_d   = bus.ex_result;
                    end else if (fault) begin
                        wb_fault_d  = 1'b1;
                        wb_reg_en_d = bus.ex_reg_en & bus.ex_is_load;
                    end else if (bus.ex_is_load) begin
                        wb_reg_en_d = bus.ex_reg_en;
                        wb_data_d   = load_data;
                    end else if (bus.ex_funct3[1:0] == 2'b10) begin
                        bus.dmem_read_write = 1'b1;
                    end else begin
                        // Sub-word store: read the surrounding word now, write the merge next cycle.
                        bus.mem_stall = 1'b1;
                        wb_valid_d    = 1'b0;
                        wb_rd_d       = 5'd0;
                        merge_d       = bus.ex_funct3[0]
                                      ? {bus.dmem_data_out[31:16], bus.ex_store_data[15:0]}
                                      : {bus.dmem_data_out[31:8],  bus.ex_store_data[7:0]};
                        addr_d        = bus.ex_addr;
                        rd_d          = bus.ex_rd;
                        size_d        = bus.ex_funct3[1:0];
                        state_d       = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                bus.dmem_address     = addr_q;
                bus.dmem_read_write  = 1'b1;
                bus.dmem_data_in     = merge_q;
                bus.dmem_access_size = size_q;
                wb_valid_d           = 1'b1;
                wb_rd_d              = rd_q;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            merge_q     <= 32'd0;
            addr_q      <= 32'd0;
            rd_q        <= 5'd0;
            size_q      <= 2'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_reg_en_q <= 1'b0;
            wb_data_q   <= 32'd0;
            wb_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            size_q      <= size_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_reg_en_q <= wb_reg_en_d;
            wb_data_q   <= wb_data_d;
            wb_fault_q  <= wb_fault_d;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_reg_en = wb_reg_en_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_fault  = wb_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with a byte-addressed
// dmemory model (4-byte writes, combinational little-endian read, 0 while writing).
module tb_mem_access_stage;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int unsigned BYTES = 1048576;
    localparam logic [31:0] LIMIT = BASE + BYTES;
    localparam int unsigned WIN   = 4096;

    logic clock;
    logic reset;
    mem_access_stage_if bus();

    mem_access_stage #(.DMEM_BASE(BASE), .DMEM_BYTES(BYTES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmemory model: two windows, one at the bottom and one at the top of the legal range.
    logic [7:0] lo_mem [WIN];
    logic [7:0] hi_mem [WIN];
    int         n_writes = 0;
    int         mem_gen  = 0;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a >= BASE && a < BASE + WIN)         return lo_mem[int'(a - BASE)];
        else if (a >= LIMIT - WIN && a < LIMIT)  return hi_mem[int'(a - (LIMIT - WIN))];
        else                                     return 8'h00;
    endfunction

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
        if (a >= BASE && a < BASE + WIN)         lo_mem[int'(a - BASE)] = b;
        else if (a >= LIMIT - WIN && a < LIMIT)  hi_mem[int'(a - (LIMIT - WIN))] = b;
    endtask

    always @(posedge clock) begin
        if (bus.dmem_read_write) begin
            for (int i = 0; i < 4; i++)
                wr_byte(bus.dmem_address + 32'(i), bus.dmem_data_in[8*i +: 8]);
            n_writes++;
            mem_gen++;
        end
    end

    always @(bus.dmem_address or bus.dmem_read_write or mem_gen) begin
        if (bus.dmem_read_write)
            bus.dmem_data_out = 32'h0;
        else
            bus.dmem_data_out = {rd_byte(bus.dmem_address + 32'd3), rd_byte(bus.dmem_address + 32'd2),
                                 rd_byte(bus.dmem_address + 32'd1), rd_byte(bus.dmem_address)};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        valid;
        logic        is_load;
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_en;
        logic        e_valid;
        logic        e_reg_en;
        logic        e_fault;
        logic        chk_data;
        logic [31:0] e_data;
        int          e_writes;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic valid, input logic ld, input logic st,
                                input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                                input logic [31:0] result, input logic [4:0] rd, input logic reg_en,
                                input logic e_valid, input logic e_reg_en, input logic e_fault,
                                input logic chk_data, input logic [31:0] e_data, input int e_writes);
        vec_t v;
        v.name = name; v.valid = valid; v.is_load = ld; v.is_store = st; v.f3 = f3;
        v.addr = addr; v.sd = sd; v.result = result; v.rd = rd; v.reg_en = reg_en;
        v.e_valid = e_valid; v.e_reg_en = e_reg_en; v.e_fault = e_fault;
        v.chk_data = chk_data; v.e_data = e_data; v.e_writes = e_writes;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        bus.ex_valid      = v.valid;
        bus.ex_is_load    = v.is_load;
        bus.ex_is_store   = v.is_store;
        bus.ex_funct3     = v.f3;
        bus.ex_addr       = v.addr;
        bus.ex_store_data = v.sd;
        bus.ex_result     = v.result;
        bus.ex_rd         = v.rd;
        bus.ex_reg_en     = v.reg_en;
    endtask

    task automatic check_wb(input vec_t v);
        check({v.name, " wb_valid"},  32'(bus.wb_valid),  32'(v.e_valid));
        check({v.name, " wb_reg_en"}, 32'(bus.wb_reg_en), 32'(v.e_reg_en));
        if (v.e_valid) begin
            check({v.name, " wb_rd"},    32'(bus.wb_rd),    32'(v.rd));
            check({v.name, " wb_fault"}, 32'(bus.wb_fault), 32'(v.e_fault));
        end
        if (v.chk_data) check({v.name, " wb_data"}, bus.wb_data, v.e_data);
    endtask

    // Single-cycle op: inputs applied just after a rising edge, results one edge later.
    task automatic run_single(input vec_t v);
        int w0;
        set_in(v);
        w0 = n_writes;
        #1;
        check({v.name, " mem_stall"}, 32'(bus.mem_stall), 32'd0);
        check({v.name, " read_write"}, 32'(bus.dmem_read_write), 32'(v.e_writes != 0));
        @(posedge clock); #1;
        check({v.name, " writes"}, 32'(n_writes - w0), 32'(v.e_writes));
        check_wb(v);
    endtask

    // SB/SH: one stall cycle with a read, then exactly one write and retirement.
    task automatic run_rmw(input vec_t v);
        int w0;
        set_in(v);
        w0 = n_writes;
        #1;
        check({v.name, " stall c0"}, 32'(bus.mem_stall), 32'd1);
        check({v.name, " rw c0"},    32'(bus.dmem_read_write), 32'd0);
        @(posedge clock); #1;
        check({v.name, " bubble"},   32'(bus.wb_valid), 32'd0);
        check({v.name, " stall c1"}, 32'(bus.mem_stall), 32'd0);
        check({v.name, " rw c1"},    32'(bus.dmem_read_write), 32'd1);
        check({v.name, " wr addr"},  bus.dmem_address, v.addr);
        @(posedge clock); #1;
        check({v.name, " writes"},   32'(n_writes - w0), 32'd1);
        check_wb(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " wb_valid"},   32'(bus.wb_valid),  32'd0);
        check({tag, " wb_rd"},      32'(bus.wb_rd),     32'd0);
        check({tag, " wb_reg_en"},  32'(bus.wb_reg_en), 32'd0);
        check({tag, " wb_data"},    bus.wb_data,        32'd0);
        check({tag, " wb_fault"},   32'(bus.wb_fault),  32'd0);
        check({tag, " read_write"}, 32'(bus.dmem_read_write), 32'd0);
        check({tag, " mem_stall"},  32'(bus.mem_stall), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(WIN); i++) begin
            lo_mem[i] = 8'h00;
            hi_mem[i] = 8'h00;
        end
        bus.dmem_data_out = 32'h0;

        //        name          vld ld st f3      addr           store data    result        rd     ren  ev er ef cd  e_data        wr
        vecs.push_back(mk("sw_beef",    1, 0, 1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, 32'h0,        5'd0,  0,   1, 0, 0, 0, 32'h0,        1));
        vecs.push_back(mk("lw_beef",    1, 1, 0, 3'b010, BASE + 32'h10, 32'h0,        32'h0,        5'd5,  1,   1, 1, 0, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk("alu_op",     1, 0, 0, 3'b000, 32'h0,         32'h0,        32'h12345678, 5'd7,  1,   1, 1, 0, 1, 32'h12345678, 0));
        vecs.push_back(mk("bubble",     0, 0, 0, 3'b000, 32'h0,         32'h0,        32'hFFFFFFFF, 5'd9,  1,   0, 0, 0, 0, 32'h0,        0));
        vecs.push_back(mk("sb_aa",      1, 0, 1, 3'b000, BASE + 32'h11, 32'h123456AA, 32'h0,        5'd4,  0,   1, 0, 0, 0, 32'h0,        1));
        vecs.push_back(mk("lw_merged",  1, 1, 0, 3'b010, BASE + 32'h10, 32'h0,        32'h0,        5'd6,  1,   1, 1, 0, 1, 32'hDEADAAEF, 0));
        vecs.push_back(mk("lb",         1, 1, 0, 3'b000, BASE + 32'h11, 32'h0,        32'h0,        5'd8,  1,   1, 1, 0, 1, 32'hFFFFFFAA, 0));
        vecs.push_back(mk("lbu",        1, 1, 0, 3'b100, BASE + 32'h11, 32'h0,        32'h0,        5'd8,  1,   1, 1, 0, 1, 32'h000000AA, 0));
        vecs.push_back(mk("lh",         1, 1, 0, 3'b001, BASE + 32'h12, 32'h0,        32'h0,        5'd10, 1,   1, 1, 0, 1, 32'hFFFFDEAD, 0));
        vecs.push_back(mk("lhu",        1, 1, 0, 3'b101, BASE + 32'h12, 32'h0,        32'h0,        5'd10, 1,   1, 1, 0, 1, 32'h0000DEAD, 0));
        vecs.push_back(mk("sw_below",   1, 0, 1, 3'b010, 32'h00FFFFFF,  32'h11111111, 32'h0,        5'd0,  0,   1, 0, 1, 0, 32'h0,        0));
        vecs.push_back(mk("lw_top_ovf", 1, 1, 0, 3'b010, LIMIT - 32'd2, 32'h0,        32'h0,        5'd11, 1,   1, 1, 1, 1, 32'h0,        0));
        vecs.push_back(mk("sw_top",     1, 0, 1, 3'b010, LIMIT - 32'd4, 32'hCAFEF00D, 32'h0,        5'd0,  0,   1, 0, 0, 0, 32'h0,        1));
        vecs.push_back(mk("lw_top",     1, 1, 0, 3'b010, LIMIT - 32'd4, 32'h0,        32'h0,        5'd12, 1,   1, 1, 0, 1, 32'hCAFEF00D, 0));
        vecs.push_back(mk("lb_last",    1, 1, 0, 3'b000, LIMIT - 32'd1, 32'h0,        32'h0,        5'd13, 1,   1, 1, 0, 1, 32'hFFFFFFCA, 0));
        vecs.push_back(mk("lh_last",    1, 1, 0, 3'b001, LIMIT - 32'd1, 32'h0,        32'h0,        5'd13, 1,   1, 1, 1, 1, 32'h0,        0));
        vecs.push_back(mk("ld_bad_f3",  1, 1, 0, 3'b011, BASE + 32'h10, 32'h0,        32'h0,        5'd14, 1,   1, 1, 1, 1, 32'h0,        0));
        vecs.push_back(mk("st_bad_f3",  1, 0, 1, 3'b100, BASE + 32'h10, 32'h55555555, 32'h0,        5'd0,  0,   1, 0, 1, 0, 32'h0,        0));
        vecs.push_back(mk("ld_and_st",  1, 1, 1, 3'b010, BASE + 32'h10, 32'h66666666, 32'h0,        5'd15, 0,   1, 0, 1, 1, 32'h0,        0));
        vecs.push_back(mk("sh_1234",    1, 0, 1, 3'b001, BASE + 32'h20, 32'hFFFF1234, 32'h0,        5'd16, 0,   1, 0, 0, 0, 32'h0,        1));
        vecs.push_back(mk("lw_sh",      1, 1, 0, 3'b010, BASE + 32'h20, 32'h0,        32'h0,        5'd17, 1,   1, 1, 0, 1, 32'h00001234, 0));

        set_in(mk("idle", 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0, 0));
        reset = 1'b0;
        #12;
        check_reset_state("por");
        reset = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            if (vecs[i].is_store && !vecs[i].is_load && vecs[i].f3 inside {3'b000, 3'b001} && !vecs[i].e_fault)
                run_rmw(vecs[i]);
            else
                run_single(vecs[i]);
        end

        // Reset asserted mid-run right after a retiring ALU op.
        run_single(mk("alu_pre_rst", 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'hA5A5A5A5, 5'd3, 1, 1, 1, 0, 1, 32'hA5A5A5A5, 0));
        bus.ex_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // SH over the merged word, with reset landing in the write cycle.
        begin
            int w0;
            set_in(mk("sh_abort", 1, 0, 1, 3'b001, BASE + 32'h10, 32'h00001234, 32'h0, 5'd18, 0, 1, 0, 0, 0, 32'h0, 1));
            #1;
            check("sh_abort stall", 32'(bus.mem_stall), 32'd1);
            @(posedge clock); #1;
            check("sh_abort rw in RMW_WR", 32'(bus.dmem_read_write), 32'd1);
            w0 = n_writes;
            #2;
            bus.ex_valid = 1'b0;
            reset = 1'b0;
            #1;
            check_reset_state("rmw_rst");
            @(posedge clock); #1;
            check("rmw_rst writes", 32'(n_writes - w0), 32'd0);
            reset = 1'b1;
            @(posedge clock); #1;
        end
        run_single(mk("lw_after_abort", 1, 1, 0, 3'b010, BASE + 32'h10, 32'h0, 32'h0, 5'd19, 1, 1, 1, 0, 1, 32'hDEADAAEF, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
